sync_fifo_wc: RTL and testbench

//  Synchronous width-converting FIFO, successor to the single-mode FIFO. Adds programmable

---
 rtl/sync_fifo_wc_if.sv | 29 ++
 rtl/sync_fifo_wc.sv | 110 +++++++++++
 tb/tb_sync_fifo_wc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_wc_if.sv
// sync_fifo_wc_if: write/read handshake and status bundle for sync_fifo_wc
interface sync_fifo_wc_if #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8,
  parameter int WR_DEPTH  = 16
);
  localparam int RD_DEPTH = WR_DEPTH * IN_WIDTH / OUT_WIDTH;
  logic                        wr_en;
  logic [IN_WIDTH-1:0]         din;
  logic                        full;
  logic                        prog_full;
  logic                        overflow;
  logic [$clog2(WR_DEPTH):0]   wr_data_count;
  logic                        rd_en;
  logic [OUT_WIDTH-1:0]        dout;
  logic                        valid;
  logic                        empty;
  logic                        prog_empty;
  logic                        underflow;
  logic [$clog2(RD_DEPTH):0]   rd_data_count;
  modport master (
    output wr_en, din, rd_en,
    input  full, prog_full, overflow, wr_data_count, dout, valid, empty, prog_empty, underflow, rd_data_count
  );
  modport slave (
    input  wr_en, din, rd_en,
    output full, prog_full, overflow, wr_data_count, dout, valid, empty, prog_empty, underflow, rd_data_count
  );
endinterface

// File: rtl/sync_fifo_wc.sv
// sync_fifo_wc: synchronous width-converting FIFO with FWFT/STD read modes and programmable flags
module sync_fifo_wc #(
  parameter int    IN_WIDTH          = 64,
  parameter int    OUT_WIDTH         = 8,
  parameter int    WR_DEPTH          = 16,
  parameter string MODE              = "FWFT",
  parameter string DIRECTION         = "LSB",
  parameter int    PROG_FULL_THRESH  = 12,
  parameter int    PROG_EMPTY_THRESH = 8
) (
  input logic           sys_clk,
  input logic           sys_rst,
  sync_fifo_wc_if.slave f
);
  localparam int U         = IN_WIDTH < OUT_WIDTH ? IN_WIDTH : OUT_WIDTH;
  localparam int MAXW      = IN_WIDTH < OUT_WIDTH ? OUT_WIDTH : IN_WIDTH;
  localparam int R         = MAXW / U;
  localparam int LR        = $clog2(R);
  localparam int WU        = IN_WIDTH / U;
  localparam int RU        = OUT_WIDTH / U;
  localparam int LWU       = $clog2(WU);
  localparam int LRU       = $clog2(RU);
  localparam int TOTAL     = WR_DEPTH * WU;
  localparam int AW        = $clog2(TOTAL);
  localparam int CW        = AW + 1;
  localparam int MEM_DEPTH = TOTAL / R;
  localparam bit FWFT      = MODE == "FWFT";
  localparam bit MSB       = DIRECTION == "MSB";
  localparam logic [CW-1:0] WU_C     = CW'(WU);
  localparam logic [CW-1:0] RU_C     = CW'(RU);
  localparam logic [CW-1:0] RU2_C    = CW'(2 * RU);
  localparam logic [CW-1:0] FULL_LIM = CW'(TOTAL - WU);
  // Storage and pointers count in units of the narrower width; one entry holds R units.
  logic [MAXW-1:0]      mem_q [MEM_DEPTH];
  logic [CW-1:0]        wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d, rd_word;
  logic                 valid_q, valid_d, full_q, full_d, empty_q, empty_d;
  logic                 prog_full_q, prog_full_d, prog_empty_q, prog_empty_d;
  logic                 overflow_q, overflow_d, underflow_q, underflow_d;
  logic                 wr_ok, rd_ok, load, avail;
  // FWFT keeps the prefetched word counted in cnt_q until the consumer acknowledges it.
  always_comb begin
    wr_ok        = f.wr_en && !full_q;
    avail        = valid_q ? cnt_q >= RU2_C : cnt_q >= RU_C;
    rd_ok        = FWFT ? f.rd_en && valid_q : f.rd_en && !empty_q;
    load         = FWFT ? avail && (!valid_q || f.rd_en) : rd_ok;
    cnt_d        = cnt_q + (wr_ok ? WU_C : '0) - (rd_ok ? RU_C : '0);
    wp_d         = wp_q + (wr_ok ? WU_C : '0);
    rp_d         = rp_q + (load ? RU_C : '0);
    dout_d       = load ? rd_word : dout_q;
    valid_d      = FWFT ? load || (valid_q && !f.rd_en) : rd_ok;
    full_d       = cnt_d > FULL_LIM;
    empty_d      = cnt_d < RU_C;
    prog_full_d  = int'(cnt_d[CW-1:LWU]) >= PROG_FULL_THRESH;
    prog_empty_d = int'(cnt_d[CW-1:LRU]) <= PROG_EMPTY_THRESH;
    overflow_d   = overflow_q || (f.wr_en && full_q);
    underflow_d  = underflow_q || (f.rd_en && (FWFT ? !valid_q : empty_q));
  end
  if (IN_WIDTH >= OUT_WIDTH) begin : g_wr_wide
    always_ff @(posedge sys_clk) if (wr_ok) mem_q[wp_q[AW-1:LR]] <= f.din;
  end else begin : g_wr_narrow
    logic [LR-1:0] lane;
    assign lane = MSB ? ~wp_q[LR-1:0] : wp_q[LR-1:0];
    always_ff @(posedge sys_clk) if (wr_ok) mem_q[wp_q[AW-1:LR]][32'(lane)*IN_WIDTH +: IN_WIDTH] <= f.din;
  end
  if (OUT_WIDTH >= IN_WIDTH) begin : g_rd_wide
    assign rd_word = mem_q[rp_q[AW-1:LR]];
  end else begin : g_rd_narrow
    logic [LR-1:0] lane;
    assign lane    = MSB ? ~rp_q[LR-1:0] : rp_q[LR-1:0];
    assign rd_word = mem_q[rp_q[AW-1:LR]][32'(lane)*OUT_WIDTH +: OUT_WIDTH];
  end
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      prog_full_q  <= prog_full_d;
      prog_empty_q <= prog_empty_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end
  assign f.dout          = dout_q;
  assign f.valid         = valid_q;
  assign f.full          = full_q;
  assign f.empty         = empty_q;
  assign f.prog_full     = prog_full_q;
  assign f.prog_empty    = prog_empty_q;
  assign f.overflow      = overflow_q;
  assign f.underflow     = underflow_q;
  assign f.wr_data_count = cnt_q[CW-1:LWU];
  assign f.rd_data_count = cnt_q[CW-1:LRU];
endmodule

// File: tb/tb_sync_fifo_wc.sv
// tb_sync_fifo_wc: byte-queue model for the 64->8 FWFT instance plus directed checks on other configurations
module tb_sync_fifo_wc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;
  localparam logic [63:0] W0  = 64'h0123456789abcdef;
  localparam logic [63:0] INC = 64'h0101010101010101;
  localparam logic [63:0] WN  = 64'hfedcba9876543210;
  logic [7:0] first_b [10] = '{8'hef, 8'hcd, 8'hab, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'hf0, 8'hce};
  logic [7:0] msb_b [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef};
  logic [7:0] new_b [8] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hba, 8'hdc, 8'hfe};
  sync_fifo_wc_if #(.IN_WIDTH(64), .OUT_WIDTH(8), .WR_DEPTH(16)) a ();
  sync_fifo_wc_if #(.IN_WIDTH(64), .OUT_WIDTH(8), .WR_DEPTH(16)) b ();
  sync_fifo_wc_if #(.IN_WIDTH(8), .OUT_WIDTH(64), .WR_DEPTH(16)) c ();
  sync_fifo_wc_if #(.IN_WIDTH(64), .OUT_WIDTH(64), .WR_DEPTH(16)) d ();
  sync_fifo_wc #(.IN_WIDTH(64), .OUT_WIDTH(8), .WR_DEPTH(16), .MODE("FWFT"), .DIRECTION("LSB")) u_a (.sys_clk(clk), .sys_rst(rst), .f(a));
  sync_fifo_wc #(.IN_WIDTH(64), .OUT_WIDTH(8), .WR_DEPTH(16), .MODE("FWFT"), .DIRECTION("MSB")) u_b (.sys_clk(clk), .sys_rst(rst), .f(b));
  sync_fifo_wc #(.IN_WIDTH(8), .OUT_WIDTH(64), .WR_DEPTH(16), .MODE("STD"), .DIRECTION("LSB")) u_c (.sys_clk(clk), .sys_rst(rst), .f(c));
  sync_fifo_wc #(.IN_WIDTH(64), .OUT_WIDTH(64), .WR_DEPTH(16), .MODE("FWFT"), .DIRECTION("LSB")) u_d (.sys_clk(clk), .sys_rst(rst), .f(d));
  initial forever #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] byte_of(input logic [63:0] w, input int i);
    return 8'(w >> (8 * i));
  endfunction
  // Model of instance a: queue of stored bytes, head shown once it was stored before the previous edge.
  logic [7:0] mq [$];
  bit mvalid = 1'b0;
  logic [7:0] mdout = '0;
  bit movf = 1'b0;
  bit munf = 1'b0;
  int mn;
  bit mwr;
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      mvalid = 1'b0;
      mdout = '0;
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      mwr = a.wr_en && (mq.size() <= 120);
      if (a.wr_en && !mwr) movf = 1'b1;
      if (a.rd_en && !mvalid) munf = 1'b1;
      mn = mq.size();
      if (a.rd_en && mvalid) begin
        void'(mq.pop_front());
        mn--;
      end
      if (mwr) for (int i = 0; i < 8; i++) mq.push_back(byte_of(a.din, i));
      mvalid = mn >= 1;
      if (mvalid) mdout = mq[0];
    end
  end
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("a_full", 64'(a.full), 64'(mq.size() > 120));
      chk("a_prog_full", 64'(a.prog_full), 64'(mq.size() / 8 >= 12));
      chk("a_overflow", 64'(a.overflow), 64'(movf));
      chk("a_wr_cnt", 64'(a.wr_data_count), 64'(mq.size() / 8));
      chk("a_empty", 64'(a.empty), 64'(mq.size() == 0));
      chk("a_prog_empty", 64'(a.prog_empty), 64'(mq.size() <= 8));
      chk("a_underflow", 64'(a.underflow), 64'(munf));
      chk("a_rd_cnt", 64'(a.rd_data_count), 64'(mq.size()));
      chk("a_valid", 64'(a.valid), 64'(mvalid));
      chk("a_dout", 64'(a.dout), 64'(mdout));
    end
  end
  initial begin
    a.wr_en = 0; a.rd_en = 0; a.din = '0;
    b.wr_en = 0; b.rd_en = 0; b.din = '0;
    c.wr_en = 0; c.rd_en = 0; c.din = '0;
    d.wr_en = 0; d.rd_en = 0; d.din = '0;
    #1 rst = 1'b0;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_empty", 64'(a.empty), 64'd1);
    chk("rst_prog_empty", 64'(a.prog_empty), 64'd1);
    chk("rst_valid", 64'(a.valid), 64'd0);
    chk("rst_full", 64'(c.full), 64'd0);
    rst = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      a.wr_en = 1;
      a.din = (k < 16) ? W0 + 64'(k) * INC : 64'hdeadbeefdeadbeef;
    end
    @(negedge clk);
    a.wr_en = 0;
    chk("t1_full", 64'(a.full), 64'd1);
    chk("t1_wr_cnt", 64'(a.wr_data_count), 64'd16);
    chk("t1_rd_cnt", 64'(a.rd_data_count), 64'd128);
    chk("t4_overflow", 64'(a.overflow), 64'd1);
    chk("t1_prog_full", 64'(a.prog_full), 64'd1);
    for (int i = 0; i < 128; i++) begin
      if (i < 10) chk("t1_lit_byte", 64'(a.dout), 64'(first_b[i]));
      chk("t1_byte", 64'(a.dout), 64'(byte_of(W0, i % 8) + 8'(i / 8)));
      chk("t1_valid", 64'(a.valid), 64'd1);
      a.rd_en = 1;
      @(negedge clk);
    end
    chk("t1_empty", 64'(a.empty), 64'd1);
    chk("t1_valid_end", 64'(a.valid), 64'd0);
    chk("t4_no_underflow", 64'(a.underflow), 64'd0);
    @(negedge clk);
    a.rd_en = 0;
    chk("t4_underflow", 64'(a.underflow), 64'd1);
    chk("t4_overflow_sticky", 64'(a.overflow), 64'd1);
    @(negedge clk);
    b.wr_en = 1;
    b.din = W0;
    @(negedge clk);
    b.wr_en = 0;
    chk("t2_valid_lat", 64'(b.valid), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("t2_msb_byte", 64'(b.dout), 64'(msb_b[i]));
      chk("t2_valid", 64'(b.valid), 64'd1);
      b.rd_en = 1;
      @(negedge clk);
    end
    b.rd_en = 0;
    chk("t2_empty", 64'(b.empty), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t3_rd_cnt_partial", 64'(c.rd_data_count), 64'd0);
      if (i == 8) chk("t3_empty_7", 64'(c.empty), 64'd1);
      c.wr_en = 1;
      c.din = 8'(i);
    end
    @(negedge clk);
    c.wr_en = 0;
    chk("t3_rd_cnt", 64'(c.rd_data_count), 64'd1);
    chk("t3_wr_cnt", 64'(c.wr_data_count), 64'd8);
    chk("t3_empty", 64'(c.empty), 64'd0);
    chk("t3_valid_idle", 64'(c.valid), 64'd0);
    c.rd_en = 1;
    @(negedge clk);
    c.rd_en = 0;
    chk("t3_valid", 64'(c.valid), 64'd1);
    chk("t3_dout", c.dout, 64'h0807060504030201);
    chk("t3_empty_after", 64'(c.empty), 64'd1);
    @(negedge clk);
    chk("t3_valid_pulse", 64'(c.valid), 64'd0);
    chk("t3_dout_hold", c.dout, 64'h0807060504030201);
    chk("t3_no_underflow", 64'(c.underflow), 64'd0);
    c.rd_en = 1;
    @(negedge clk);
    c.rd_en = 0;
    chk("t3_underflow", 64'(c.underflow), 64'd1);
    chk("t3_underflow_valid", 64'(c.valid), 64'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      d.wr_en = 1;
      d.din = 64'(k);
    end
    @(negedge clk);
    d.wr_en = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("t5_dout", d.dout, 64'(i));
      chk("t5_wr_cnt", 64'(d.wr_data_count), 64'd12);
      chk("t5_prog_full", 64'(d.prog_full), 64'd1);
      chk("t5_valid", 64'(d.valid), 64'd1);
      d.rd_en = 1;
      d.wr_en = 1;
      d.din = 64'(12 + i);
      @(negedge clk);
    end
    d.rd_en = 0;
    d.wr_en = 0;
    chk("t5_dout_end", d.dout, 64'd10);
    chk("t5_rd_cnt_end", 64'(d.rd_data_count), 64'd12);
    chk("t5_prog_full_end", 64'(d.prog_full), 64'd1);
    @(negedge clk);
    a.wr_en = 1;
    a.din = 64'h1111111111111111;
    @(negedge clk);
    a.din = 64'h2222222222222222;
    @(negedge clk);
    a.wr_en = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a.rd_en = 1;
      @(negedge clk);
    end
    a.rd_en = 0;
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", 64'(a.valid), 64'd0);
    chk("t6_dout", 64'(a.dout), 64'd0);
    chk("t6_empty", 64'(a.empty), 64'd1);
    chk("t6_prog_empty", 64'(a.prog_empty), 64'd1);
    chk("t6_full", 64'(a.full), 64'd0);
    chk("t6_overflow", 64'(a.overflow), 64'd0);
    chk("t6_underflow", 64'(a.underflow), 64'd0);
    chk("t6_wr_cnt", 64'(a.wr_data_count), 64'd0);
    chk("t6_rd_cnt", 64'(a.rd_data_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    a.wr_en = 1;
    a.din = WN;
    @(negedge clk);
    a.wr_en = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("t6_new_byte", 64'(a.dout), 64'(new_b[i]));
      a.rd_en = 1;
      @(negedge clk);
    end
    a.rd_en = 0;
    chk("t6_empty_end", 64'(a.empty), 64'd1);
    @(negedge clk);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
